// File: rtl/midi_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : midi_out_arbiter
// Purpose  : Shares one MIDI output among four synchronized MIDI inputs,
//            handing ownership over only at frame-idle boundaries.
// Option   : define MIDI_ARB_DROP_CNT_EN to add the drop_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module midi_out_arbiter #(
    parameter int         CLK_DIV    = 256,
    parameter int         IDLE_BITS  = 10,
    parameter int         BREAK_BITS = 10,
    parameter logic [3:0] MASK_RST   = 4'b1111
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [3:0] midi_in,
    input  logic [3:0] cfg_mask,
    input  logic       cfg_wr,
    output logic       midi_out,
    output logic [3:0] grant,
    output logic       busy,
    output logic       cfg_pending
`ifdef MIDI_ARB_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    localparam int c_idle_cyc  = CLK_DIV * IDLE_BITS;
    localparam int c_break_cyc = CLK_DIV * BREAK_BITS;
    localparam int c_q_w       = $clog2(c_idle_cyc) + 1;
    localparam int c_lc_w      = $clog2(c_break_cyc) + 1;

    localparam logic [c_q_w-1:0]  c_q_max  = c_q_w'(c_idle_cyc);
    localparam logic [c_lc_w-1:0] c_lc_brk = c_lc_w'(c_break_cyc);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;

    logic [0:0]        r_state;
    logic [3:0]        r_prev_in;
    logic [3:0]        r_mask;
    logic [3:0]        r_shadow;
    logic [3:0]        r_grant;
    logic [1:0]        r_gidx;
    logic [1:0]        r_last;
    logic              r_midi_out;
    logic              r_busy;
    logic              r_pending;
    logic [c_lc_w-1:0] r_lc;

    logic [3:0]        w_armed;
    logic [3:0]        w_req;
    logic              w_any_req;
    logic [1:0]        w_pick;
    logic              w_found;
    logic              w_gin;
    logic [c_lc_w-1:0] w_lc_next;

    // Quiet counters: an input is armed once it has been high for a full idle period.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_quiet
            logic [c_q_w-1:0] r_q;
            always_ff @(posedge clk) begin
                if (!nreset) begin
                    r_q <= '0;
                end else if (!midi_in[gi]) begin
                    r_q <= '0;
                end else if (r_q != c_q_max) begin
                    r_q <= r_q + c_q_w'(1);
                end
            end
            assign w_armed[gi] = (r_q == c_q_max);
        end
    endgenerate

    assign w_req     = r_mask & w_armed & r_prev_in & ~midi_in;
    assign w_any_req = |w_req;

    // Round-robin: scan starting just after the last owner, wrapping mod 4.
    always_comb begin
        w_pick  = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && w_req[r_last + 2'(k)]) begin
                w_pick  = r_last + 2'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_gin     = midi_in[r_gidx];
    assign w_lc_next = w_gin ? '0 : r_lc + c_lc_w'(1);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state    <= c_st_idle;
            r_prev_in  <= 4'hF;
            r_mask     <= MASK_RST;
            r_shadow   <= MASK_RST;
            r_grant    <= 4'b0000;
            r_gidx     <= 2'd0;
            r_last     <= 2'd3;
            r_midi_out <= 1'b1;
            r_busy     <= 1'b0;
            r_pending  <= 1'b0;
            r_lc       <= '0;
        end else begin
            r_prev_in <= midi_in;
            if (cfg_wr) begin
                r_shadow  <= cfg_mask;
                r_pending <= 1'b1;
            end
            case (r_state)
                c_st_idle: begin
                    r_midi_out <= 1'b1;
                    if (w_any_req) begin
                        r_state    <= c_st_grant;
                        r_grant    <= 4'b0001 << w_pick;
                        r_gidx     <= w_pick;
                        r_midi_out <= 1'b0;
                        r_busy     <= 1'b1;
                        r_lc       <= c_lc_w'(1);
                    end else if (r_pending) begin
                        // A write landing in the apply cycle stays pending for the next apply.
                        r_mask <= r_shadow;
                        if (!cfg_wr) begin
                            r_pending <= 1'b0;
                        end
                    end
                end
                c_st_grant: begin
                    r_midi_out <= w_gin;
                    r_lc       <= w_lc_next;
                    if (w_armed[r_gidx] || (w_lc_next == c_lc_brk)) begin
                        r_state    <= c_st_idle;
                        r_grant    <= 4'b0000;
                        r_last     <= r_gidx;
                        r_busy     <= 1'b0;
                        r_midi_out <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign midi_out    = r_midi_out;
    assign grant       = r_grant;
    assign busy        = r_busy;
    assign cfg_pending = r_pending;

`ifdef MIDI_ARB_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic [2:0] w_req_cnt;
    logic [2:0] w_drops;
    logic [8:0] w_drop_sum;

    assign w_req_cnt = 3'(w_req[0]) + 3'(w_req[1]) + 3'(w_req[2]) + 3'(w_req[3]);
    // In IDLE the winner is not a drop; every request during GRANT is.
    assign w_drops    = (r_state == c_st_grant) ? w_req_cnt :
                        (w_any_req ? (w_req_cnt - 3'd1) : 3'd0);
    assign w_drop_sum = {1'b0, r_drop_cnt} + {6'd0, w_drops};

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_drop_cnt <= 8'd0;
        end else if (cfg_wr) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop_sum[8]) begin
            r_drop_cnt <= 8'hFF;
        end else begin
            r_drop_cnt <= w_drop_sum[7:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_midi_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_midi_out_arbiter
// Purpose  : Self-checking bench: directed scenarios plus random traffic,
//            compared every cycle against a behavioural arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_midi_out_arbiter;

    localparam int IDLE_CYC  = 2560;
    localparam int BREAK_CYC = 2560;

    logic       clk = 1'b0;
    logic       nreset;
    logic [3:0] midi_in;
    logic [3:0] cfg_mask;
    logic       cfg_wr;
    logic       midi_out;
    logic [3:0] grant;
    logic       busy;
    logic       cfg_pending;
`ifdef MIDI_ARB_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    midi_out_arbiter dut (
        .clk         (clk),
        .nreset      (nreset),
        .midi_in     (midi_in),
        .cfg_mask    (cfg_mask),
        .cfg_wr      (cfg_wr),
        .midi_out    (midi_out),
        .grant       (grant),
        .busy        (busy),
        .cfg_pending (cfg_pending)
`ifdef MIDI_ARB_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: owner is -1 when nobody holds the output.
    int       m_quiet[4] = '{0, 0, 0, 0};
    int       m_owner    = -1;
    int       m_low      = 0;
    int       m_last     = 3;
    int       m_drops    = 0;
    bit [3:0] m_mask     = 4'hF;
    bit [3:0] m_shadow   = 4'hF;
    bit [3:0] m_prev     = 4'hF;
    bit       m_pend     = 1'b0;
    bit       m_out      = 1'b1;

    always @(posedge clk) begin : model
        bit [3:0] req;
        int       nreq;
        int       g;
        if (!nreset) begin
            for (int i = 0; i < 4; i++) m_quiet[i] = 0;
            m_owner = -1; m_low = 0; m_last = 3; m_drops = 0;
            m_mask = 4'hF; m_shadow = 4'hF; m_prev = 4'hF;
            m_pend = 1'b0; m_out = 1'b1;
        end else begin
            nreq = 0;
            for (int i = 0; i < 4; i++) begin
                req[i] = m_mask[i] && (m_quiet[i] == IDLE_CYC) && m_prev[i] && !midi_in[i];
                if (req[i]) nreq++;
            end
            if (m_owner < 0) begin
                m_out = 1'b1;
                if (nreq > 0) begin
                    g = -1;
                    for (int k = 1; k <= 4; k++)
                        if (g < 0 && req[(m_last + k) % 4]) g = (m_last + k) % 4;
                    m_owner = g;
                    m_out   = 1'b0;
                    m_low   = 1;
                    m_drops += nreq - 1;
                end else if (m_pend) begin
                    m_mask = m_shadow;
                    m_pend = 1'b0;
                end
            end else begin
                m_drops += nreq;
                m_out = midi_in[m_owner];
                m_low = midi_in[m_owner] ? 0 : m_low + 1;
                if (m_quiet[m_owner] == IDLE_CYC || m_low == BREAK_CYC) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_out   = 1'b1;
                end
            end
            if (m_drops > 255) m_drops = 255;
            if (cfg_wr) begin
                m_shadow = cfg_mask;
                m_pend   = 1'b1;
                m_drops  = 0;
            end
            for (int i = 0; i < 4; i++)
                m_quiet[i] = !midi_in[i] ? 0 : (m_quiet[i] < IDLE_CYC ? m_quiet[i] + 1 : IDLE_CYC);
            m_prev = midi_in;
        end
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model midi_out", 8'(midi_out), 8'(m_out));
            check("model grant", 8'(grant), (m_owner < 0) ? 8'd0 : 8'(1 << m_owner));
            check("model busy", 8'(busy), 8'(m_owner >= 0));
            check("model cfg_pending", 8'(cfg_pending), 8'(m_pend));
`ifdef MIDI_ARB_DROP_CNT_EN
            check("model drop_cnt", drop_cnt, 8'(m_drops));
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // 8N1 frame, 256 clk/bit; grant is checked one clock after the start edge.
    task automatic send_frame(input logic [3:0] chs, input logic [7:0] data,
                              input logic [3:0] exp_grant, input string nm,
                              input bit cfg_pulse, input logic [3:0] cfg_val);
        logic lvl;
        for (int b = 0; b < 10; b++) begin
            lvl = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : data[b-1]);
            for (int c = 0; c < 4; c++) if (chs[c]) midi_in[c] = lvl;
            for (int t = 0; t < 256; t++) begin
                if (b == 0 && t == 1 && cfg_pulse) begin
                    cfg_mask = cfg_val;
                    cfg_wr   = 1'b1;
                end
                tick;
                cfg_wr = 1'b0;
                if (b == 0 && t == 0) check(nm, 8'(grant), 8'(exp_grant));
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int waited;
        waited = 0;
        while (grant != 4'd0 && waited < budget) begin
            tick;
            waited++;
        end
        if (grant != 4'd0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle timeout: grant %b expected 0000", grant);
        end
    endtask

    int seg[4];
    bit lvl_r[4];

    initial begin
        nreset   = 1'b0;
        midi_in  = 4'hF;
        cfg_mask = 4'h0;
        cfg_wr   = 1'b0;
        tick;
        chk_en = 1'b1;

        // Reset held with inputs toggling.
        for (int i = 0; i < 50; i++) begin
            midi_in = 4'($urandom);
            tick;
            check("rst midi_out", 8'(midi_out), 8'd1);
            check("rst grant", 8'(grant), 8'd0);
            check("rst busy", 8'(busy), 8'd0);
            check("rst cfg_pending", 8'(cfg_pending), 8'd0);
        end
        midi_in = 4'hF;
        nreset  = 1'b1;
        repeat (2600) tick;

        // Single frame on input 0; line last rises at data bit 7, release 2560 clks later.
        send_frame(4'b0001, 8'h90, 4'b0001, "t2 grant0", 1'b0, 4'h0);
        repeat (2048) tick;
        check("t2 still granted", 8'(grant), 8'h01);
        tick;
        check("t2 released", 8'(grant), 8'h00);

        // Simultaneous starts on 1 and 2 with last=0.
        send_frame(4'b0110, 8'h3C, 4'b0010, "t3 grant1", 1'b0, 4'h0);
`ifdef MIDI_ARB_DROP_CNT_EN
        check("t3 drop_cnt", drop_cnt, 8'd1);
`endif
        wait_idle(6000);

        // Round robin from last=1.
        send_frame(4'b1010, 8'hA5, 4'b1000, "t4 grant3", 1'b0, 4'h0);
        wait_idle(6000);

        // Mask write while input 0 owns the output.
        send_frame(4'b0001, 8'h90, 4'b0001, "t5 grant0", 1'b1, 4'b0100);
        check("t5 pending in frame", 8'(cfg_pending), 8'd1);
        wait_idle(6000);
        check("t5 pending at release", 8'(cfg_pending), 8'd1);
        tick;
        check("t5 pending applied", 8'(cfg_pending), 8'd0);
        send_frame(4'b0001, 8'h00, 4'b0000, "t5 in0 masked", 1'b0, 4'h0);
        send_frame(4'b0100, 8'h12, 4'b0100, "t5 grant2", 1'b0, 4'h0);
        wait_idle(6000);

        // Stuck-low granted input: break at the 2560th low sample.
        midi_in[2] = 1'b0;
        tick;
        check("t6 grant2", 8'(grant), 8'h04);
        repeat (2558) tick;
        check("t6 before break", 8'(grant), 8'h04);
        tick;
        check("t6 break grant", 8'(grant), 8'h00);
        check("t6 break midi_out", 8'(midi_out), 8'd1);
        repeat (4000 - 2560) tick;
        midi_in[2] = 1'b1;
        repeat (1000) tick;
        midi_in[2] = 1'b0;
        tick;
        check("t6 no regrant", 8'(grant), 8'h00);
        midi_in[2] = 1'b1;
        repeat (2600) tick;
        midi_in[2] = 1'b0;
        tick;
        check("t6 regrant", 8'(grant), 8'h04);

        // Reset mid-frame.
        repeat (100) tick;
        nreset = 1'b0;
        tick;
        check("midframe rst midi_out", 8'(midi_out), 8'd1);
        check("midframe rst grant", 8'(grant), 8'd0);
        check("midframe rst busy", 8'(busy), 8'd0);
        midi_in = 4'hF;
        tick;
        nreset = 1'b1;

        // Random bit-timed traffic with occasional breaks, mask writes and resets.
        for (int i = 0; i < 4; i++) begin
            seg[i]   = $urandom_range(1, 3000);
            lvl_r[i] = 1'b1;
        end
        for (int n = 0; n < 25000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (seg[i] == 0) begin
                    lvl_r[i] = !lvl_r[i];
                    if (lvl_r[i]) seg[i] = $urandom_range(1, 14) * 256;
                    else seg[i] = ($urandom_range(0, 19) == 0) ? 3000 : $urandom_range(1, 4) * 256;
                end
                seg[i]--;
                midi_in[i] = lvl_r[i];
            end
            cfg_wr = ($urandom_range(0, 499) == 0);
            if (cfg_wr) cfg_mask = 4'($urandom);
            nreset = !($urandom_range(0, 9999) == 0);
            tick;
        end
        cfg_wr = 1'b0;
        nreset = 1'b1;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
